// File: rtl/nibbler_control_unit.sv
// nibbler_control_unit: instruction fetch/decode/sequencer for the Nibbler 4-bit CPU.
// Drives ALU mode, accumulator/output load strobes and keeps the carry/zero flags.
// Optional feature macro: NIBBLER_ILLEGAL_TRAP_EN (opcodes A-F trap into HALT).
`timescale 1ns/1ps

module nibbler_control_unit #(
  parameter int unsigned PC_W = 12
) (
  input  logic            clk,
  input  logic            notReset,
  input  logic            run,
  input  logic [7:0]      instr,
  input  logic            notC,
  input  logic            notZ,
  output logic [PC_W-1:0] pc,
  output logic [3:0]      imm,
  output logic [2:0]      S,
  output logic            notCarryIn,
  output logic            notOeALU,
  output logic            notLoadA,
  output logic            notLoadOut,
  output logic            flagC,
  output logic            flagZ,
  output logic            halted,
  output logic            illegal
);

  localparam logic [3:0] OP_LIT  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_CMPI = 4'h3;
  localparam logic [3:0] OP_NORI = 4'h4;
  localparam logic [3:0] OP_OUT  = 4'h5;
  localparam logic [3:0] OP_JC   = 4'h6;
  localparam logic [3:0] OP_JNZ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'h9;

  // ALU mode encodings as {notCarryIn, S}
  localparam logic [3:0] MODE_IDLE = 4'b1000;
  localparam logic [3:0] MODE_LIT  = 4'b1010;
  localparam logic [3:0] MODE_ADD  = 4'b1011;
  localparam logic [3:0] MODE_CMP  = 4'b0001;
  localparam logic [3:0] MODE_NOR  = 4'b1100;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_ADDR  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [7:0]      ir_q;
  logic [3:0]      imm_q;
  logic [3:0]      mode_q;
  logic            oe_n_q;
  logic            load_a_n_q;
  logic            load_out_n_q;
  logic            flag_c_q;
  logic            flag_z_q;
  logic            halted_q;
  logic            illegal_q;

  logic [3:0]      dec_mode_d;
  logic            dec_oe_n_d;
  logic            dec_load_a_n_d;
  logic            dec_load_out_n_d;
  logic [PC_W-1:0] pc_inc_d;
  logic [PC_W-1:0] jump_target_d;
  logic            jump_taken_d;
  logic            trap_d;

  // Decode the byte being fetched into the EXEC-cycle ALU mode and strobes
  always_comb begin
    dec_mode_d       = MODE_IDLE;
    dec_oe_n_d       = 1'b1;
    dec_load_a_n_d   = 1'b1;
    dec_load_out_n_d = 1'b1;
    case (instr[7:4])
      OP_LIT:  begin dec_mode_d = MODE_LIT; dec_oe_n_d = 1'b0; dec_load_a_n_d = 1'b0; end
      OP_ADDI: begin dec_mode_d = MODE_ADD; dec_oe_n_d = 1'b0; dec_load_a_n_d = 1'b0; end
      OP_CMPI: dec_mode_d = MODE_CMP;
      OP_NORI: begin dec_mode_d = MODE_NOR; dec_oe_n_d = 1'b0; dec_load_a_n_d = 1'b0; end
      OP_OUT:  dec_load_out_n_d = 1'b0;
      default: ;
    endcase
  end

  // Jump resolution uses only flags latched by earlier EXEC cycles
  always_comb begin
    pc_inc_d      = pc_q + PC_W'(1);
    jump_target_d = PC_W'({ir_q[3:0], instr});
    jump_taken_d  = 1'b0;
    case (ir_q[7:4])
      OP_JC:   jump_taken_d = flag_c_q;
      OP_JNZ:  jump_taken_d = ~flag_z_q;
      OP_JMP:  jump_taken_d = 1'b1;
      default: jump_taken_d = 1'b0;
    endcase
`ifdef NIBBLER_ILLEGAL_TRAP_EN
    trap_d = (ir_q[7:4] >= 4'hA);
`else
    trap_d = 1'b0;
`endif
  end

  // Sequencer FSM with registered outputs; strobes default inactive every cycle
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state_q      <= ST_FETCH;
      pc_q         <= '0;
      ir_q         <= '0;
      imm_q        <= '0;
      mode_q       <= MODE_IDLE;
      oe_n_q       <= 1'b1;
      load_a_n_q   <= 1'b1;
      load_out_n_q <= 1'b1;
      flag_c_q     <= 1'b0;
      flag_z_q     <= 1'b0;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      mode_q       <= MODE_IDLE;
      oe_n_q       <= 1'b1;
      load_a_n_q   <= 1'b1;
      load_out_n_q <= 1'b1;
      case (state_q)
        ST_FETCH: begin
          if (run) begin
            ir_q         <= instr;
            imm_q        <= instr[3:0];
            mode_q       <= dec_mode_d;
            oe_n_q       <= dec_oe_n_d;
            load_a_n_q   <= dec_load_a_n_d;
            load_out_n_q <= dec_load_out_n_d;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (ir_q[7:4])
            OP_ADDI: begin
              flag_c_q <= ~notC;
              flag_z_q <= ~notZ;
              pc_q     <= pc_inc_d;
              state_q  <= ST_FETCH;
            end
            OP_CMPI, OP_NORI: begin
              flag_z_q <= ~notZ;
              pc_q     <= pc_inc_d;
              state_q  <= ST_FETCH;
            end
            OP_JC, OP_JNZ, OP_JMP: begin
              pc_q    <= pc_inc_d;
              state_q <= ST_ADDR;
            end
            OP_HALT: begin
              pc_q     <= pc_inc_d;
              halted_q <= 1'b1;
              state_q  <= ST_HALT;
            end
            default: begin
              if (trap_d) begin
                illegal_q <= 1'b1;
                halted_q  <= 1'b1;
                state_q   <= ST_HALT;
              end else begin
                pc_q    <= pc_inc_d;
                state_q <= ST_FETCH;
              end
            end
          endcase
        end
        ST_ADDR: begin
          pc_q    <= jump_taken_d ? jump_target_d : pc_inc_d;
          state_q <= ST_FETCH;
        end
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  assign pc         = pc_q;
  assign imm        = imm_q;
  assign notCarryIn = mode_q[3];
  assign S          = mode_q[2:0];
  assign notOeALU   = oe_n_q;
  assign notLoadA   = load_a_n_q;
  assign notLoadOut = load_out_n_q;
  assign flagC      = flag_c_q;
  assign flagZ      = flag_z_q;
  assign halted     = halted_q;
`ifdef NIBBLER_ILLEGAL_TRAP_EN
  assign illegal    = illegal_q;
`else
  assign illegal    = 1'b0;
`endif

endmodule

// File: tb/tb_nibbler_control_unit.sv
// tb_nibbler_control_unit: directed bench with a ROM, a small ALU and accumulator model.
`timescale 1ns/1ps

module tb_nibbler_control_unit;

  logic        clk = 1'b0;
  logic        notReset = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  instr;
  logic        notC;
  logic        notZ;
  logic [11:0] pc;
  logic [3:0]  imm;
  logic [2:0]  S;
  logic        notCarryIn;
  logic        notOeALU;
  logic        notLoadA;
  logic        notLoadOut;
  logic        flagC;
  logic        flagZ;
  logic        halted;
  logic        illegal;

  logic [7:0]  rom [0:4095];
  logic [3:0]  acc = 4'h0;
  logic [3:0]  out_q = 4'h0;
  logic [3:0]  alu_res;
  logic [4:0]  sum5;
  logic [3:0]  mode;
  logic [3:0]  acc_before;
  int          n_tests = 0;
  int          n_fail = 0;

  nibbler_control_unit #(.PC_W(12)) dut (
    .clk(clk), .notReset(notReset), .run(run), .instr(instr),
    .notC(notC), .notZ(notZ), .pc(pc), .imm(imm), .S(S),
    .notCarryIn(notCarryIn), .notOeALU(notOeALU), .notLoadA(notLoadA),
    .notLoadOut(notLoadOut), .flagC(flagC), .flagZ(flagZ),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign instr = rom[pc];
  assign mode  = {notCarryIn, S};

  // ALU model: LIT passes imm, ADD, CMP (A - imm), NOR; carry/zero active-low
  always_comb begin
    sum5    = 5'd0;
    alu_res = acc;
    case (mode)
      4'b1010: alu_res = imm;
      4'b1011: begin sum5 = {1'b0, acc} + {1'b0, imm}; alu_res = sum5[3:0]; end
      4'b0001: begin sum5 = {1'b0, acc} + {1'b0, ~imm} + 5'd1; alu_res = sum5[3:0]; end
      4'b1100: alu_res = ~(acc | imm);
      default: alu_res = acc;
    endcase
    notC = ~sum5[4];
    notZ = (alu_res != 4'h0);
  end

  // Accumulator and output port respond to the active-low strobes
  always @(posedge clk) begin
    if (notLoadA === 1'b0)   acc   <= alu_res;
    if (notLoadOut === 1'b0) out_q <= acc;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
  endtask

  // Hold reset for two cycles, then release on a falling edge with the given run level
  task automatic do_reset(input logic run_val);
    notReset = 1'b0;
    run      = 1'b0;
    cyc(2);
    run      = run_val;
    notReset = 1'b1;
  endtask

  task automatic test_reset();
    rom_clear();
    do_reset(1'b0);
    notReset = 1'b0;
    #1;
    n_tests++; if (pc !== 12'h000) begin n_fail++; $display("FAIL rst_pc got %h exp %h", pc, 12'h000); end
    n_tests++; if (imm !== 4'h0) begin n_fail++; $display("FAIL rst_imm got %h exp %h", imm, 4'h0); end
    n_tests++; if (mode !== 4'b1000) begin n_fail++; $display("FAIL rst_mode got %b exp %b", mode, 4'b1000); end
    n_tests++; if ({notOeALU, notLoadA, notLoadOut} !== 3'b111) begin n_fail++; $display("FAIL rst_strobes got %b exp %b", {notOeALU, notLoadA, notLoadOut}, 3'b111); end
    n_tests++; if ({flagC, flagZ, halted, illegal} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags got %b exp %b", {flagC, flagZ, halted, illegal}, 4'b0000); end
  endtask

  task automatic test_program();
    rom_clear();
    rom[0] = 8'h15; rom[1] = 8'h23; rom[2] = 8'h50;
    do_reset(1'b1);
    cyc(1);
    n_tests++; if ({notLoadA, imm} !== 5'b0_0101) begin n_fail++; $display("FAIL prog_c2_loada got %b exp %b", {notLoadA, imm}, 5'b0_0101); end
    n_tests++; if ({mode, notOeALU} !== 5'b1010_0) begin n_fail++; $display("FAIL prog_c2_mode got %b exp %b", {mode, notOeALU}, 5'b1010_0); end
    cyc(1);
    n_tests++; if ({notLoadA, acc} !== 5'b1_0101) begin n_fail++; $display("FAIL prog_c3 got %b exp %b", {notLoadA, acc}, 5'b1_0101); end
    cyc(1);
    n_tests++; if ({notLoadA, imm, mode} !== 9'b0_0011_1011) begin n_fail++; $display("FAIL prog_c4 got %b exp %b", {notLoadA, imm, mode}, 9'b0_0011_1011); end
    cyc(1);
    n_tests++; if ({acc, flagC, flagZ, notLoadOut} !== 7'b1000_00_1) begin n_fail++; $display("FAIL prog_c5 got %b exp %b", {acc, flagC, flagZ, notLoadOut}, 7'b1000_00_1); end
    cyc(1);
    n_tests++; if ({notLoadOut, notLoadA} !== 2'b01) begin n_fail++; $display("FAIL prog_c6_out got %b exp %b", {notLoadOut, notLoadA}, 2'b01); end
    cyc(1);
    run = 1'b0;
    n_tests++; if ({out_q, pc} !== {4'h8, 12'h003}) begin n_fail++; $display("FAIL prog_c7 got %h exp %h", {out_q, pc}, {4'h8, 12'h003}); end
    cyc(3);
    n_tests++; if (pc !== 12'h003) begin n_fail++; $display("FAIL prog_stall_pc got %h exp %h", pc, 12'h003); end
  endtask

  task automatic test_addi_jc_taken();
    rom_clear();
    rom[0] = 8'h1F; rom[1] = 8'h21; rom[12'h010] = 8'h61; rom[12'h011] = 8'h23;
    do_reset(1'b1);
    cyc(4);
    n_tests++; if ({flagC, flagZ, acc, pc} !== {2'b11, 4'h0, 12'h002}) begin n_fail++; $display("FAIL addi_flags got %h exp %h", {flagC, flagZ, acc, pc}, {2'b11, 4'h0, 12'h002}); end
    cyc(28);
    n_tests++; if (pc !== 12'h010) begin n_fail++; $display("FAIL jc_pc_fetch got %h exp %h", pc, 12'h010); end
    cyc(2);
    n_tests++; if ({pc, notLoadA} !== {12'h011, 1'b1}) begin n_fail++; $display("FAIL jc_pc_addr got %h exp %h", {pc, notLoadA}, {12'h011, 1'b1}); end
    cyc(1);
    n_tests++; if (pc !== 12'h123) begin n_fail++; $display("FAIL jc_taken got %h exp %h", pc, 12'h123); end
  endtask

  task automatic test_jc_not_taken();
    rom_clear();
    rom[0] = 8'h11; rom[1] = 8'h21; rom[12'h010] = 8'h61; rom[12'h011] = 8'h23;
    do_reset(1'b1);
    cyc(4);
    n_tests++; if ({flagC, flagZ, acc} !== {2'b00, 4'h2}) begin n_fail++; $display("FAIL addi_nc got %h exp %h", {flagC, flagZ, acc}, {2'b00, 4'h2}); end
    cyc(31);
    n_tests++; if (pc !== 12'h012) begin n_fail++; $display("FAIL jc_not_taken got %h exp %h", pc, 12'h012); end
  endtask

  task automatic test_cmpi_jnz();
    rom_clear();
    rom[0] = 8'h14; rom[1] = 8'h34; rom[2] = 8'h71; rom[3] = 8'h23;
    do_reset(1'b1);
    cyc(3);
    n_tests++; if ({mode, notOeALU, notLoadA} !== 6'b0001_11) begin n_fail++; $display("FAIL cmpi_mode got %b exp %b", {mode, notOeALU, notLoadA}, 6'b0001_11); end
    cyc(1);
    n_tests++; if ({flagZ, flagC, acc} !== {2'b10, 4'h4}) begin n_fail++; $display("FAIL cmpi_eq_flags got %h exp %h", {flagZ, flagC, acc}, {2'b10, 4'h4}); end
    cyc(3);
    n_tests++; if (pc !== 12'h004) begin n_fail++; $display("FAIL jnz_not_taken got %h exp %h", pc, 12'h004); end
    rom[0] = 8'h15;
    do_reset(1'b1);
    cyc(4);
    n_tests++; if ({flagZ, acc} !== {1'b0, 4'h5}) begin n_fail++; $display("FAIL cmpi_ne_flags got %h exp %h", {flagZ, acc}, {1'b0, 4'h5}); end
    cyc(3);
    n_tests++; if (pc !== 12'h123) begin n_fail++; $display("FAIL jnz_taken got %h exp %h", pc, 12'h123); end
  endtask

  task automatic test_jmp_nori();
    rom_clear();
    rom[0] = 8'h8A; rom[1] = 8'hBC;
    do_reset(1'b1);
    cyc(2);
    n_tests++; if (pc !== 12'h001) begin n_fail++; $display("FAIL jmp_addr_pc got %h exp %h", pc, 12'h001); end
    cyc(1);
    n_tests++; if (pc !== 12'hABC) begin n_fail++; $display("FAIL jmp_target got %h exp %h", pc, 12'hABC); end
    rom_clear();
    rom[0] = 8'h1F; rom[1] = 8'h40;
    do_reset(1'b1);
    cyc(3);
    n_tests++; if ({mode, notOeALU, notLoadA} !== 6'b1100_00) begin n_fail++; $display("FAIL nori_mode got %b exp %b", {mode, notOeALU, notLoadA}, 6'b1100_00); end
    cyc(1);
    n_tests++; if ({acc, flagZ, flagC} !== {4'h0, 2'b10}) begin n_fail++; $display("FAIL nori_result got %h exp %h", {acc, flagZ, flagC}, {4'h0, 2'b10}); end
  endtask

  task automatic test_halt();
    rom_clear();
    rom[0] = 8'h90; rom[1] = 8'h15;
    do_reset(1'b1);
    cyc(2);
    n_tests++; if ({halted, pc} !== {1'b1, 12'h001}) begin n_fail++; $display("FAIL halt_enter got %h exp %h", {halted, pc}, {1'b1, 12'h001}); end
    for (int i = 0; i < 6; i++) begin
      run = i[0];
      cyc(1);
      n_tests++; if ({halted, pc, notLoadA, notLoadOut, notOeALU} !== {1'b1, 12'h001, 3'b111}) begin n_fail++; $display("FAIL halt_hold_%0d got %h exp %h", i, {halted, pc, notLoadA, notLoadOut, notOeALU}, {1'b1, 12'h001, 3'b111}); end
    end
  endtask

  task automatic test_reset_mid_exec();
    rom_clear();
    rom[0] = 8'h21;
    do_reset(1'b1);
    cyc(1);
    acc_before = acc;
    n_tests++; if (notLoadA !== 1'b0) begin n_fail++; $display("FAIL rmid_in_exec got %b exp %b", notLoadA, 1'b0); end
    notReset = 1'b0;
    #1;
    n_tests++; if ({notLoadA, notOeALU, pc} !== {2'b11, 12'h000}) begin n_fail++; $display("FAIL rmid_async got %h exp %h", {notLoadA, notOeALU, pc}, {2'b11, 12'h000}); end
    cyc(2);
    n_tests++; if ({acc, notLoadA, pc} !== {acc_before, 1'b1, 12'h000}) begin n_fail++; $display("FAIL rmid_no_load got %h exp %h", {acc, notLoadA, pc}, {acc_before, 1'b1, 12'h000}); end
  endtask

  task automatic test_run_stall();
    rom_clear();
    rom[0] = 8'h15;
    do_reset(1'b0);
    cyc(5);
    n_tests++; if ({pc, notLoadA} !== {12'h000, 1'b1}) begin n_fail++; $display("FAIL stall_hold got %h exp %h", {pc, notLoadA}, {12'h000, 1'b1}); end
    run = 1'b1;
    cyc(1);
    run = 1'b0;
    n_tests++; if (notLoadA !== 1'b0) begin n_fail++; $display("FAIL stall_exec got %b exp %b", notLoadA, 1'b0); end
    cyc(1);
    n_tests++; if ({pc, acc} !== {12'h001, 4'h5}) begin n_fail++; $display("FAIL stall_completes got %h exp %h", {pc, acc}, {12'h001, 4'h5}); end
    cyc(3);
    n_tests++; if ({pc, notLoadA} !== {12'h001, 1'b1}) begin n_fail++; $display("FAIL stall_refetch got %h exp %h", {pc, notLoadA}, {12'h001, 1'b1}); end
  endtask

  task automatic test_illegal();
    rom_clear();
    rom[0] = 8'hB0;
    do_reset(1'b1);
    cyc(1);
    n_tests++; if ({mode, notLoadA, notLoadOut} !== 6'b1000_11) begin n_fail++; $display("FAIL illegal_exec got %b exp %b", {mode, notLoadA, notLoadOut}, 6'b1000_11); end
    cyc(1);
`ifdef NIBBLER_ILLEGAL_TRAP_EN
    n_tests++; if ({illegal, halted, pc} !== {2'b11, 12'h000}) begin n_fail++; $display("FAIL illegal_trap got %h exp %h", {illegal, halted, pc}, {2'b11, 12'h000}); end
    cyc(3);
    n_tests++; if ({illegal, pc} !== {1'b1, 12'h000}) begin n_fail++; $display("FAIL illegal_sticky got %h exp %h", {illegal, pc}, {1'b1, 12'h000}); end
`else
    n_tests++; if ({illegal, halted, pc} !== {2'b00, 12'h001}) begin n_fail++; $display("FAIL illegal_nop got %h exp %h", {illegal, halted, pc}, {2'b00, 12'h001}); end
`endif
  endtask

  task automatic test_pc_wrap();
    rom_clear();
    do_reset(1'b1);
    cyc(8190);
    n_tests++; if (pc !== 12'hFFF) begin n_fail++; $display("FAIL wrap_top got %h exp %h", pc, 12'hFFF); end
    cyc(2);
    n_tests++; if ({pc, halted} !== {12'h000, 1'b0}) begin n_fail++; $display("FAIL wrap_zero got %h exp %h", {pc, halted}, {12'h000, 1'b0}); end
  endtask

  initial begin
    rom_clear();
    test_reset();
    test_program();
    test_addi_jc_taken();
    test_jc_not_taken();
    test_cmpi_jnz();
    test_jmp_nori();
    test_halt();
    test_reset_mid_exec();
    test_run_stall();
    test_illegal();
    test_pc_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nibbler_control_unit.md
# nibbler_control_unit

Instruction sequencer for the Nibbler 4-bit CPU. It fetches 8-bit instruction bytes from program ROM using a 12-bit program counter, decodes them, and drives the ALU mode controls (notCarryIn, S[2:0], notOeALU). It also drives the accumulator/output-port load strobes and keeps the registered carry/zero flags used by conditional jumps. It sits between program ROM, the ALU and the accumulator register.

## Interface
- PC_W, 12, program counter / ROM address width
- clk  input  1  system clock, rising edge
- notReset  input  1  asynchronous, active-low reset
- run  input  1  1 = advance; 0 = hold in FETCH (stall)
- instr  input  8  ROM data at address pc; opcode = instr[7:4], imm = instr[3:0]
- notC  input  1  ALU carry, active-low, combinational from ALU
- notZ  input  1  ALU zero, active-low, combinational from ALU
- pc  output  PC_W  ROM address
- imm  output  4  registered immediate, drives ALU operand bus
- S  output  3  ALU function select
- notCarryIn  output  1  ALU mode bit 3
- notOeALU  output  1  ALU result output enable, active-low
- notLoadA  output  1  accumulator load strobe, active-low, one cycle
- notLoadOut  output  1  output-port load strobe, active-low, one cycle
- flagC, flagZ  output  1  registered flags, active-high
- halted  output  1  in HALT state
- illegal  output  1  sticky illegal-opcode flag (macro only, else tied 0)

## Operation
- States: FETCH, EXEC, ADDR, HALT.
- FETCH: if run=1, latch instr into IR, go to EXEC. If run=0, stay in FETCH.
- EXEC: drive the ALU mode per opcode. On the clock edge: load strobes take effect, selected flags latch, pc <= pc+1.
- Opcode map, with ALU mode given as {notCarryIn,S}:
  - 0 NOP: mode 1000.
  - 1 LIT: mode 1010, notLoadA=0, flags unchanged.
  - 2 ADDI: mode 1011, notLoadA=0, flagC<=~notC, flagZ<=~notZ.
  - 3 CMPI: mode 0001, A unchanged, flagZ<=~notZ only.
  - 4 NORI: mode 1100, notLoadA=0, flagZ<=~notZ only.
  - 5 OUT: mode 1000, notLoadOut=0.
  - 6 JC, 7 JNZ, 8 JMP: two-byte instructions. Next state ADDR.
  - 9 HALT: next state HALT.
  - A–F: treated as NOP.
- ADDR: instr holds the low target byte. Jump target = {IR.imm, instr} (zero-extended when PC_W>12).
  - JMP always takes the target.
  - JC takes the target if flagC=1.
  - JNZ takes the target if flagZ=0.
  - Otherwise pc <= pc+1. Next state FETCH.
- HALT: all strobes inactive, pc frozen, halted=1. Only reset exits.
- notOeALU=0 only in EXEC for LIT/ADDI/NORI; 1 otherwise.
- pc wraps from 2^PC_W−1 to 0 with no flag or trap.

## Timing
- Reset (async assert, sync release by next edge): state FETCH, pc=0, IR=0, imm=0, mode 1000, notOeALU=1, notLoadA=1, notLoadOut=1, flagC=0, flagZ=0, halted=0, illegal=0.
- Reset asserted mid-EXEC or mid-ADDR: outputs go to reset values immediately; no strobe completes.
- All outputs are registered or decoded from state+IR only; no combinational path from instr/notC/notZ to outputs.
- Single-byte instruction: 2 cycles (FETCH, EXEC). Jump: 3 cycles (FETCH, EXEC, ADDR).
- Flags used by a jump are those latched at the end of earlier EXEC cycles. A jump never samples the live notC/notZ.
- run is sampled only in FETCH. Deasserting it in EXEC/ADDR does not stall the current instruction.
- Strobes are exactly one cycle wide, in EXEC only.

## Configuration
- NIBBLER_ILLEGAL_TRAP_EN defined: opcodes A–F set illegal=1 (sticky until reset) and go to HALT from EXEC. pc is not incremented, so it points at the offending byte.
- Not defined: opcodes A–F execute as NOP, and illegal is tied 0.

## Test plan
- Reset, ROM {0x15, 0x23, 0x50}, run=1 → notLoadA pulses in cycles 2 and 4 with imm 5 then 3; with the ALU modelled, A=8. notLoadOut pulses in cycle 6; flagC=0, flagZ=0; pc=3.
- A=0xF, ADDI 1 (0x21) → notC=0 and notZ=0 from ALU; after EXEC, flagC=1, flagZ=1, A=0.
- JC with flagC=1, bytes {0x61, 0x23} at pc=0x010 → pc=0x123 after ADDR. Repeat with flagC=0 → pc=0x012.
- CMPI 4 with A=4 then JNZ → flagZ=1, branch not taken. With A=5 → branch taken.
- HALT (0x90) then toggle run → halted=1, pc frozen, no strobes. Assert notReset mid-EXEC of an ADDI → notLoadA stays 1 and pc=0.
- Opcode 0xB: with NIBBLER_ILLEGAL_TRAP_EN defined → illegal=1, halted=1, pc unchanged. Without it → behaves as NOP, pc+1.
